// File: rtl/shift_pkg.sv
// Shared types and constants for the shift-register command sequencer.
package shift_pkg;

  localparam int unsigned SHIFT_WIDTH = 15;
  localparam int unsigned SHIFT_CNT_W = 8;

  localparam logic [2:0] MODE_HOLD    = 3'd0;
  localparam logic [2:0] MODE_MIN     = 3'd1;
  localparam logic [2:0] MODE_MAX     = 3'd6;
  localparam logic [2:0] MODE_ILLEGAL = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DONE,
    ERR
  } seq_state_e;

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode >= MODE_MIN) && (mode <= MODE_MAX);
  endfunction

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// Command handshake bundle between a command source and the sequencer.
interface shift_cmd_if #(
  parameter int unsigned WIDTH = shift_pkg::SHIFT_WIDTH,
  parameter int unsigned CNT_W = shift_pkg::SHIFT_CNT_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_mode;
  logic [WIDTH:0]   cmd_amount;
  logic [WIDTH:0]   cmd_data;
  logic [CNT_W-1:0] cmd_cycles;
  logic             abort;

  modport master (
    output cmd_valid, cmd_mode, cmd_amount, cmd_data, cmd_cycles, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_amount, cmd_data, cmd_cycles, abort,
    output cmd_ready
  );
endinterface

// File: rtl/shift_run_counter.sv
// Loadable run-length down-counter; clear beats load beats decrement.
module shift_run_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             clr,
  output logic             is_zero,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero = (cnt_q == '0);
  assign is_one  = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/shift_cmd_sequencer.sv
// Sequencer driving the universal shift register: one-cycle load strobe,
// mode held for a programmed run length, then back to hold with status pulse.
module shift_cmd_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = SHIFT_WIDTH,
  parameter int unsigned CNT_W = SHIFT_CNT_W
) (
  input  logic           clk,
  input  logic           res,
  shift_cmd_if.slave     cmd,
  output logic [2:0]     set,
  output logic [WIDTH:0] M,
  output logic [WIDTH:0] D,
  output logic           enable,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic           aborted
);

  seq_state_e     state_q, state_d;
  logic [2:0]     set_q, set_d;
  logic [WIDTH:0] amount_q, amount_d;
  logic [WIDTH:0] data_q, data_d;
  logic           enable_q, enable_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           aborted_q, aborted_d;

  logic cnt_load, cnt_dec, cnt_clr, cnt_zero, cnt_one;

  shift_run_counter #(.CNT_W(CNT_W)) u_run_counter (
    .clk      (clk),
    .res      (res),
    .load     (cnt_load),
    .load_val (cmd.cmd_cycles),
    .dec      (cnt_dec),
    .clr      (cnt_clr),
    .is_zero  (cnt_zero),
    .is_one   (cnt_one)
  );

  assign cmd.cmd_ready = (state_q == IDLE);

  // Outputs are computed for the next state so every output is a flop.
  // The counter is loaded on the accept edge, so during LOAD it already
  // holds cmd_cycles and needs no separate cycles register.
  always_comb begin
    state_d   = state_q;
    set_d     = MODE_HOLD;
    amount_d  = amount_q;
    data_d    = data_q;
    enable_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cnt_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          if (mode_is_legal(cmd.cmd_mode)) begin
            state_d  = LOAD;
            set_d    = cmd.cmd_mode;
            amount_d = cmd.cmd_amount;
            data_d   = cmd.cmd_data;
            enable_d = 1'b1;
            busy_d   = 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      LOAD, RUN: begin
        cnt_dec = (state_q == RUN);
        if (cmd.abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          cnt_clr   = 1'b1;
        end else if ((state_q == LOAD) ? cnt_zero : cnt_one) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
          set_d   = set_q;
          busy_d  = 1'b1;
        end
      end
      DONE, ERR: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      set_q     <= MODE_HOLD;
      amount_q  <= '0;
      data_q    <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      set_q     <= set_d;
      amount_q  <= amount_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  assign set     = set_q;
  assign M       = amount_q;
  assign D       = data_q;
  assign enable  = enable_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer with hand-computed per-cycle tables.
module tb_shift_cmd_sequencer;

  logic        clk;
  logic        res;
  logic [2:0]  set;
  logic [15:0] M, D;
  logic        enable, busy, done, err, aborted;
  logic [8:0]  status;

  int n_checks = 0;
  int n_fail   = 0;

  shift_cmd_if #(.WIDTH(15), .CNT_W(8)) cmd_if ();

  shift_cmd_sequencer #(.WIDTH(15), .CNT_W(8)) dut (
    .clk     (clk),
    .res     (res),
    .cmd     (cmd_if),
    .set     (set),
    .M       (M),
    .D       (D),
    .enable  (enable),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .aborted (aborted)
  );

  // status = {set, enable, busy, done, err, aborted, cmd_ready}
  assign status = {set, enable, busy, done, err, aborted, cmd_if.cmd_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] mk(input logic [2:0] s, input logic [5:0] flags);
    return {s, flags};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] mo, input logic [15:0] am,
                       input logic [15:0] dt, input logic [7:0] cy);
    cmd_if.cmd_valid  = v;
    cmd_if.cmd_mode   = mo;
    cmd_if.cmd_amount = am;
    cmd_if.cmd_data   = dt;
    cmd_if.cmd_cycles = cy;
  endtask

  task automatic test_reset();
    res = 1'b1;
    cmd_if.abort = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 8'd0);
    #2;
    res = 1'b0;
    #1;
    n_checks++;
    if (status !== mk(3'd0, 6'b000001)) begin
      n_fail++; $display("FAIL reset_async_status got=%b exp=%b", status, mk(3'd0, 6'b000001));
    end
    step(); step();
    n_checks++;
    if ({M, D} !== 32'h0) begin
      n_fail++; $display("FAIL reset_md got=%h exp=%h", {M, D}, 32'h0);
    end
    res = 1'b1;
    step();
    n_checks++;
    if (status !== mk(3'd0, 6'b000001)) begin
      n_fail++; $display("FAIL reset_release_status got=%b exp=%b", status, mk(3'd0, 6'b000001));
    end
  endtask

  task automatic test_basic();
    logic [8:0] es [7];
    es[0] = mk(3'd3, 6'b110000);
    for (int i = 1; i <= 4; i++) es[i] = mk(3'd3, 6'b010000);
    es[5] = mk(3'd0, 6'b001000);
    es[6] = mk(3'd0, 6'b000001);
    drive(1'b1, 3'd3, 16'h0002, 16'h0A5E, 8'd4);
    step();
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (status !== es[i]) begin
        n_fail++; $display("FAIL basic_status cyc=N+%0d got=%b exp=%b", i + 1, status, es[i]);
      end
      n_checks++;
      if ({M, D} !== {16'h0002, 16'h0A5E}) begin
        n_fail++; $display("FAIL basic_md cyc=N+%0d got=%h exp=%h", i + 1, {M, D}, {16'h0002, 16'h0A5E});
      end
      step();
    end
  endtask

  task automatic test_zero_cycles();
    logic [8:0]  es [6];
    logic [31:0] emd [6];
    es[0] = mk(3'd5, 6'b110000); emd[0] = {16'h0003, 16'h1234};
    es[1] = mk(3'd0, 6'b001000); emd[1] = {16'h0003, 16'h1234};
    es[2] = mk(3'd0, 6'b000001); emd[2] = {16'h0003, 16'h1234};
    es[3] = mk(3'd2, 6'b110000); emd[3] = {16'h0001, 16'hBEEF};
    es[4] = mk(3'd0, 6'b001000); emd[4] = {16'h0001, 16'hBEEF};
    es[5] = mk(3'd0, 6'b000001); emd[5] = {16'h0001, 16'hBEEF};
    drive(1'b1, 3'd5, 16'h0003, 16'h1234, 8'd0);
    step();
    drive(1'b1, 3'd2, 16'h0001, 16'hBEEF, 8'd0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (status !== es[i]) begin
        n_fail++; $display("FAIL zero_status cyc=N+%0d got=%b exp=%b", i + 1, status, es[i]);
      end
      n_checks++;
      if ({M, D} !== emd[i]) begin
        n_fail++; $display("FAIL zero_md cyc=N+%0d got=%h exp=%h", i + 1, {M, D}, emd[i]);
      end
      if (i == 3) cmd_if.cmd_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_illegal();
    logic [2:0] modes [2];
    modes[0] = 3'd7;
    modes[1] = 3'd0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, modes[k], 16'hFFFF, 16'hDEAD, 8'd3);
      step();
      cmd_if.cmd_valid = 1'b0;
      n_checks++;
      if (status !== mk(3'd0, 6'b000100)) begin
        n_fail++; $display("FAIL illegal_err mode=%0d got=%b exp=%b", modes[k], status, mk(3'd0, 6'b000100));
      end
      n_checks++;
      if ({M, D} !== {16'h0001, 16'hBEEF}) begin
        n_fail++; $display("FAIL illegal_md mode=%0d got=%h exp=%h", modes[k], {M, D}, {16'h0001, 16'hBEEF});
      end
      step();
      n_checks++;
      if (status !== mk(3'd0, 6'b000001)) begin
        n_fail++; $display("FAIL illegal_idle mode=%0d got=%b exp=%b", modes[k], status, mk(3'd0, 6'b000001));
      end
    end
    step();
  endtask

  task automatic test_abort();
    logic [8:0]  es [9];
    logic [31:0] emd [9];
    es[0] = mk(3'd4, 6'b110000);
    for (int i = 1; i <= 3; i++) es[i] = mk(3'd4, 6'b010000);
    es[4] = mk(3'd0, 6'b000011);
    es[5] = mk(3'd1, 6'b110000);
    es[6] = mk(3'd1, 6'b010000);
    es[7] = mk(3'd0, 6'b001000);
    es[8] = mk(3'd0, 6'b000001);
    for (int i = 0; i < 9; i++) emd[i] = (i < 5) ? {16'h0005, 16'h00FF} : {16'h0007, 16'h5555};
    drive(1'b1, 3'd4, 16'h0005, 16'h00FF, 8'd10);
    step();
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (status !== es[i]) begin
        n_fail++; $display("FAIL abort_status cyc=N+%0d got=%b exp=%b", i + 1, status, es[i]);
      end
      n_checks++;
      if ({M, D} !== emd[i]) begin
        n_fail++; $display("FAIL abort_md cyc=N+%0d got=%h exp=%h", i + 1, {M, D}, emd[i]);
      end
      case (i)
        3: begin cmd_if.abort = 1'b1; drive(1'b1, 3'd1, 16'h0007, 16'h5555, 8'd1); end
        4: cmd_if.abort = 1'b0;
        5: cmd_if.cmd_valid = 1'b0;
        7: cmd_if.abort = 1'b1;
        8: cmd_if.abort = 1'b0;
        default: ;
      endcase
      step();
    end
  endtask

  task automatic test_abort_last();
    logic [8:0] es [5];
    es[0] = mk(3'd2, 6'b110000);
    es[1] = mk(3'd2, 6'b010000);
    es[2] = mk(3'd2, 6'b010000);
    es[3] = mk(3'd0, 6'b000011);
    es[4] = mk(3'd0, 6'b000001);
    drive(1'b1, 3'd2, 16'h0009, 16'h6666, 8'd2);
    step();
    cmd_if.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (status !== es[i]) begin
        n_fail++; $display("FAIL abort_last_status cyc=N+%0d got=%b exp=%b", i + 1, status, es[i]);
      end
      cmd_if.abort = (i == 2);
      step();
    end
    n_checks++;
    if ({M, D} !== {16'h0009, 16'h6666}) begin
      n_fail++; $display("FAIL abort_last_md got=%h exp=%h", {M, D}, {16'h0009, 16'h6666});
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  es [9];
    logic [31:0] emd [9];
    es[0] = mk(3'd1, 6'b110000);
    es[1] = mk(3'd1, 6'b010000);
    es[2] = mk(3'd1, 6'b010000);
    es[3] = mk(3'd0, 6'b001000);
    es[4] = mk(3'd0, 6'b000001);
    es[5] = mk(3'd6, 6'b110000);
    es[6] = mk(3'd6, 6'b010000);
    es[7] = mk(3'd0, 6'b001000);
    es[8] = mk(3'd0, 6'b000001);
    for (int i = 0; i < 9; i++) emd[i] = (i < 5) ? {16'h0001, 16'hAAAA} : {16'h000F, 16'h1357};
    drive(1'b1, 3'd1, 16'h0001, 16'hAAAA, 8'd2);
    step();
    drive(1'b1, 3'd6, 16'h000F, 16'h1357, 8'd1);
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (status !== es[i]) begin
        n_fail++; $display("FAIL b2b_status cyc=N+%0d got=%b exp=%b", i + 1, status, es[i]);
      end
      n_checks++;
      if ({M, D} !== emd[i]) begin
        n_fail++; $display("FAIL b2b_md cyc=N+%0d got=%h exp=%h", i + 1, {M, D}, emd[i]);
      end
      if (i == 5) cmd_if.cmd_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 3'd6, 16'h0004, 16'hC3C3, 8'd5);
    step();
    cmd_if.cmd_valid = 1'b0;
    step();
    n_checks++;
    if (status !== mk(3'd6, 6'b010000)) begin
      n_fail++; $display("FAIL rstmid_run got=%b exp=%b", status, mk(3'd6, 6'b010000));
    end
    #4;
    res = 1'b0;
    #1;
    n_checks++;
    if (status !== mk(3'd0, 6'b000001)) begin
      n_fail++; $display("FAIL rstmid_async_status got=%b exp=%b", status, mk(3'd0, 6'b000001));
    end
    n_checks++;
    if ({M, D} !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async_md got=%h exp=%h", {M, D}, 32'h0);
    end
    res = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (status !== mk(3'd0, 6'b000001)) begin
        n_fail++; $display("FAIL rstmid_after cyc=%0d got=%b exp=%b", i, status, mk(3'd0, 6'b000001));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_cycles();
    test_illegal();
    test_abort();
    test_abort_last();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_cmd_sequencer.md
Name: shift_cmd_sequencer

Overview:
Command sequencer that sits directly upstream of the universal shift register and drives its set, M, D and enable inputs. It accepts one shift command at a time over a valid/ready handshake. For each command it loads the register through a one-cycle enable pulse, then holds the requested mode for a programmed number of clocks. It then returns the register to hold and reports completion, replacing the hand-timed set/enable stimulus with a reusable stage.

Parameters:
WIDTH, 15, MSB index of the data path; data, M and D are WIDTH+1 bits (16 by default)
CNT_W, 8, width of the run-length counter; maximum run is 2^CNT_W-1 clocks

Ports:
clk  input  1  system clock, rising edge
res  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_mode  input  3  shift-register mode to apply; legal values are 1..6
cmd_amount  input  WIDTH+1  shift amount, forwarded to M
cmd_data  input  WIDTH+1  load word, forwarded to D
cmd_cycles  input  CNT_W  number of clocks to hold the mode after the load
abort  input  1  cancel the current command
set  output  3  mode to the shift register; 0 means hold
M  output  WIDTH+1  shift amount to the shift register
D  output  WIDTH+1  data to the shift register
enable  output  1  load strobe to the shift register
busy  output  1  a command is in progress
done  output  1  one-cycle pulse when a command completes normally
err  output  1  one-cycle pulse when a command has an illegal mode
aborted  output  1  one-cycle pulse when a command is cancelled

Behaviour:
- Clock and reset: one clock domain. res is asynchronous and active-low; when res=0, all state clears immediately, without waiting for a clock edge.
- Reset values: state=IDLE, set=0, M=0, D=0, enable=0, busy=0, done=0, err=0, aborted=0, counter=0; cmd_ready=1 after reset.
- Registered outputs: all outputs except cmd_ready are registered. cmd_ready = (state==IDLE) and is decoded from the state register.
- Handshake: a transfer occurs on a rising edge with cmd_valid && cmd_ready. The mode, amount, data and cycles fields are captured on that edge. cmd_valid while not ready is ignored; the command is neither latched nor lost, because the source must hold it.
- IDLE: set=0, enable=0. On transfer with mode in 1..6: next state LOAD. On transfer with mode 0 or 7: next state ERR.
- LOAD (exactly 1 cycle): set=mode, M=amount, D=data, enable=1, busy=1. Next state RUN if cycles!=0, otherwise DONE. The counter loads cycles.
- RUN: set=mode, enable=0, busy=1. The counter decrements every clock. Leave to DONE in the cycle the counter reaches 1, so the mode is held for exactly cmd_cycles clocks after the LOAD cycle.
- DONE (1 cycle): set=0, enable=0, done=1, busy=0. Next state IDLE.
- ERR (1 cycle): err=1, set=0, enable=0. M and D keep their previous values. Next state IDLE; the shift register is never touched.
- Latency: command accepted at edge N → enable high in cycle N+1 → done high in cycle N+2+cmd_cycles → cmd_ready high in cycle N+3+cmd_cycles.
- abort:
  - Sampled only in LOAD or RUN.
  - Next cycle: aborted=1, set=0, enable=0, counter cleared, state IDLE. done is not pulsed.
  - If abort coincides with the counter reaching 1, abort wins.
  - abort in IDLE, DONE or ERR is ignored.
- M and D hold their last loaded values after completion. Only set and enable return to idle values.
- Reset mid-command: all outputs go to their reset values asynchronously and no status pulse is produced.
- Pulses: done, err and aborted are mutually exclusive and never high for 2 consecutive cycles.

Decomposition:
- Shared package (shift_pkg) contains:
  - mode constants: MODE_HOLD=0, legal range 1..6, MODE_ILLEGAL=7;
  - state encoding: IDLE, LOAD, RUN, DONE, ERR;
  - default WIDTH=15.
- One natural sub-module, shift_run_counter: a loadable down-counter with load, dec, clr and a zero/one flag, CNT_W wide, also using clk and res.
- Everything else stays in a single FSM module.

Test Plan:
- Reset: res pulsed low for 1 ns mid-cycle → all outputs 0 immediately, cmd_ready=1.
- Basic command: mode=3, amount=2, data=16'h0A5E, cycles=4 → enable=1 for exactly 1 cycle with D=16'h0A5E and M=2; set=3 for 5 cycles (LOAD plus 4 RUN); done pulse at accept+6 cycles; set=0 afterwards.
- Zero cycles: cmd_cycles=0, mode=5 → LOAD then DONE, set=5 for 1 cycle, done at accept+2, next accept possible at accept+3.
- Illegal mode: mode=7 and then mode=0 → err pulse at accept+1, enable never asserts, set stays 0, M and D unchanged.
- Abort: cycles=10, abort asserted on the 3rd RUN cycle → aborted=1 the next cycle, set=0, no done; a second command with cmd_valid held high is accepted the following cycle.
- Back-to-back: two commands presented continuously (mode 1 with cycles=2, then mode 6 with cycles=1) → second transfer exactly 1 cycle after the first done; no gap or overlap in busy except the DONE cycle; scoreboard checks set, M and D per cycle against a reference model.
